// File: rtl/vrom_seq_pkg.sv
`default_nettype none
// ============================================================================
// vrom_seq_pkg : shared types and field widths for the V ROM bus sequencer
// Revision     : 1.0
// ============================================================================
package vrom_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ALO       = 3'd1,
      S_ALO_LATCH = 3'd2,
      S_AHI       = 3'd3,
      S_AHI_LATCH = 3'd4,
      S_READ      = 3'd5,
      S_DONE      = 3'd6
   } vrom_state_t;

   localparam int VROM_ADDR_W = 24;
   localparam int LO_W        = 10;
   localparam int HI_W        = 14;
   localparam int RAD_W       = 8;
   localparam int RA_L_W      = 2;
   localparam int RA_U_W      = 4;

endpackage
`default_nettype wire

// File: rtl/vrom_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// vrom_bus_sequencer_if : channel request side and multiplexed V ROM bus
// Revision              : 1.0
// ============================================================================
interface vrom_bus_sequencer_if #(
   parameter int NUM_REQ = 6
);
   import vrom_seq_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]             REQ;
   logic [NUM_REQ*VROM_ADDR_W-1:0] REQ_ADDR;
   logic [NUM_REQ-1:0]             ACK;
   logic [RAD_W-1:0]               RD_DATA;
   logic [IDX_W-1:0]               GNT_IDX;
   logic                           BUSY;
   logic [RAD_W-1:0]               RAD_OUT;
   logic                           RAD_OE;
   logic [RAD_W-1:0]               RAD_IN;
   logic [RA_L_W-1:0]              RA_L;
   logic [RA_U_W-1:0]              RA_U;
   logic                           RMPX;
   logic                           nROE;

   modport master (
      input  REQ, REQ_ADDR, RAD_IN,
      output ACK, RD_DATA, GNT_IDX, BUSY, RAD_OUT, RAD_OE, RA_L, RA_U, RMPX, nROE
   );

   modport slave (
      output REQ, REQ_ADDR, RAD_IN,
      input  ACK, RD_DATA, GNT_IDX, BUSY, RAD_OUT, RAD_OE, RA_L, RA_U, RMPX, nROE
   );

endinterface
`default_nettype wire

// File: rtl/vrom_rr_arbiter.sv
`default_nettype none
// ============================================================================
// vrom_rr_arbiter : combinational winner select; round-robin with a pointer
//                   register when VROM_SEQ_RR_EN is defined, else fixed priority
// Revision        : 1.0
// ============================================================================
module vrom_rr_arbiter #(
   parameter int NUM_REQ = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       ptr_load,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_val,
   output logic                       win_valid,
   output logic [$clog2(NUM_REQ)-1:0] win_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

`ifdef VROM_SEQ_RR_EN
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [31:0]      cand;

   always_comb begin
      ptr_d = ptr_load ? ptr_val : ptr_q;
   end

   // Reset to the last index so the first search after reset starts at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = 32'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (32'(ptr_q) + 32'(i) + 32'd1) % 32'(NUM_REQ);
         if (!win_valid && req[IDX_W'(cand)]) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end
`else
   logic unused_ptr;

   // Descending scan so the lowest set index is the one left standing.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'(i);
         end
      end
   end

   assign unused_ptr = &{1'b0, clk, rst, ptr_load, ptr_val};
`endif

endmodule
`default_nettype wire

// File: rtl/vrom_bus_sequencer.sv
`default_nettype none
// ============================================================================
// vrom_bus_sequencer : arbitrates channel fetches and runs the two-phase
//                      RMPX address multiplex plus nROE read on the V ROM bus
//                      (VROM_SEQ_RR_EN selects round-robin arbitration)
// Revision           : 1.0
// ============================================================================
module vrom_bus_sequencer #(
   parameter int NUM_REQ  = 6,
   parameter int READ_CYC = 2
) (
   input  logic                  CLK_8M,
   input  logic                  RESET,
   vrom_bus_sequencer_if.master  bus
);
   import vrom_seq_pkg::*;

   localparam int             IDX_W     = $clog2(NUM_REQ);
   localparam logic [3:0]     READ_LAST = 4'(READ_CYC - 1);

   vrom_state_t               state_q, state_d;
   logic [VROM_ADDR_W-1:0]    addr_q, addr_d;
   logic [3:0]                cnt_q, cnt_d;
   logic [IDX_W-1:0]          gnt_idx_q, gnt_idx_d;
   logic [NUM_REQ-1:0]        ack_q, ack_d;
   logic [RAD_W-1:0]          rd_data_q, rd_data_d;
   logic                      busy_q, busy_d;
   logic [RAD_W-1:0]          rad_out_q, rad_out_d;
   logic                      rad_oe_q, rad_oe_d;
   logic [RA_L_W-1:0]         ra_l_q, ra_l_d;
   logic [RA_U_W-1:0]         ra_u_q, ra_u_d;
   logic                      rmpx_q, rmpx_d;
   logic                      nroe_q, nroe_d;

   logic [LO_W-1:0]           lo_half;
   logic [HI_W-1:0]           hi_half;
   logic                      win_valid;
   logic [IDX_W-1:0]          win_idx;
   logic [VROM_ADDR_W-1:0]    req_addr_a [NUM_REQ];

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr_unpack
         assign req_addr_a[g] = bus.REQ_ADDR[g*VROM_ADDR_W +: VROM_ADDR_W];
      end
   endgenerate

   vrom_rr_arbiter #(
      .NUM_REQ   (NUM_REQ)
   ) u_arb (
      .clk       (CLK_8M),
      .rst       (RESET),
      .req       (bus.REQ),
      .ptr_load  (state_q == S_DONE),
      .ptr_val   (gnt_idx_q),
      .win_valid (win_valid),
      .win_idx   (win_idx)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      gnt_idx_d = gnt_idx_q;
      rd_data_d = rd_data_q;
      ack_d     = '0;
      rad_out_d = rad_out_q;
      rad_oe_d  = 1'b0;
      ra_l_d    = ra_l_q;
      ra_u_d    = ra_u_q;
      rmpx_d    = 1'b0;
      nroe_d    = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (win_valid) begin
               state_d   = S_ALO;
               gnt_idx_d = win_idx;
               addr_d    = req_addr_a[win_idx];
            end
         end
         S_ALO:       state_d = S_ALO_LATCH;
         S_ALO_LATCH: state_d = S_AHI;
         S_AHI:       state_d = S_AHI_LATCH;
         S_AHI_LATCH: begin
            state_d = S_READ;
            cnt_d   = 4'd0;
         end
         S_READ: begin
            if (cnt_q == READ_LAST) begin
               state_d   = S_DONE;
               rd_data_d = bus.RAD_IN;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so every pin comes straight from a flop.
      lo_half = addr_d[LO_W-1:0];
      hi_half = addr_d[VROM_ADDR_W-1:LO_W];
      busy_d  = (state_d != S_IDLE);

      case (state_d)
         S_ALO, S_ALO_LATCH: begin
            rad_oe_d  = 1'b1;
            rad_out_d = lo_half[RAD_W-1:0];
            ra_l_d    = lo_half[LO_W-1:RAD_W];
            rmpx_d    = (state_d == S_ALO_LATCH);
         end
         S_AHI, S_AHI_LATCH: begin
            rad_oe_d  = 1'b1;
            rad_out_d = hi_half[RAD_W-1:0];
            ra_l_d    = hi_half[RAD_W+RA_L_W-1:RAD_W];
            ra_u_d    = hi_half[HI_W-1:RAD_W+RA_L_W];
            rmpx_d    = (state_d == S_AHI);
         end
         S_READ: nroe_d = 1'b0;
         S_DONE: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               ack_d[i] = (gnt_idx_d == IDX_W'(i));
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK_8M or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         gnt_idx_q <= '0;
         ack_q     <= '0;
         rd_data_q <= '0;
         busy_q    <= 1'b0;
         rad_out_q <= '0;
         rad_oe_q  <= 1'b0;
         ra_l_q    <= '0;
         ra_u_q    <= '0;
         rmpx_q    <= 1'b0;
         nroe_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         gnt_idx_q <= gnt_idx_d;
         ack_q     <= ack_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
         rad_out_q <= rad_out_d;
         rad_oe_q  <= rad_oe_d;
         ra_l_q    <= ra_l_d;
         ra_u_q    <= ra_u_d;
         rmpx_q    <= rmpx_d;
         nroe_q    <= nroe_d;
      end
   end

   assign bus.ACK     = ack_q;
   assign bus.RD_DATA = rd_data_q;
   assign bus.GNT_IDX = gnt_idx_q;
   assign bus.BUSY    = busy_q;
   assign bus.RAD_OUT = rad_out_q;
   assign bus.RAD_OE  = rad_oe_q;
   assign bus.RA_L    = ra_l_q;
   assign bus.RA_U    = ra_u_q;
   assign bus.RMPX    = rmpx_q;
   assign bus.nROE    = nroe_q;

endmodule
`default_nettype wire

// File: tb/tb_vrom_bus_sequencer.sv
`default_nettype none
// ============================================================================
// tb_vrom_bus_sequencer : scoreboard bench for two sequencer instances
//                         (READ_CYC=2 and READ_CYC=5)
// Revision              : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vrom_bus_sequencer;

   localparam int NREQ = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vrom_bus_sequencer_if #(.NUM_REQ(NREQ)) bus_a ();
   vrom_bus_sequencer_if #(.NUM_REQ(NREQ)) bus_b ();

   vrom_bus_sequencer #(.NUM_REQ(NREQ), .READ_CYC(2)) dut_a (
      .CLK_8M (clk),
      .RESET  (rst),
      .bus    (bus_a)
   );

   vrom_bus_sequencer #(.NUM_REQ(NREQ), .READ_CYC(5)) dut_b (
      .CLK_8M (clk),
      .RESET  (rst),
      .bus    (bus_b)
   );

   typedef struct {
      int         ch;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [7:0] lo_rad;
      logic [1:0] lo_ral;
      logic [7:0] hi_rad;
      logic [1:0] hi_ral;
      logic [3:0] hi_rau;
   } ph_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   ph_t  ph_a[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic ph_t ph_of(input logic [23:0] a);
      ph_t p;
      p.lo_rad = a[7:0];
      p.lo_ral = a[9:8];
      p.hi_rad = a[17:10];
      p.hi_ral = a[19:18];
      p.hi_rau = a[23:20];
      return p;
   endfunction

   task automatic set_addr_a(input int ch, input logic [23:0] a);
      bus_a.REQ_ADDR[ch*24 +: 24] = a;
   endtask

   task automatic push_a(input int ch, input logic [7:0] d, input int at, input logic [23:0] a);
      exp_a.push_back('{ch, d, at});
      ph_a.push_back(ph_of(a));
   endtask

   task automatic wait_acks(input bit use_b, input int n, input string name);
      int got = 0;
      for (int t = 0; t < 200 && got < n; t++) begin
         @(negedge clk);
         if ((use_b ? bus_b.ACK : bus_a.ACK) != '0) got++;
      end
      if (got < n) chk({name, "_ack_timeout"}, 32'(got), 32'(n));
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_ack"},     32'(bus_a.ACK),     32'd0);
      chk({tag, "_rd_data"}, 32'(bus_a.RD_DATA), 32'd0);
      chk({tag, "_gnt_idx"}, 32'(bus_a.GNT_IDX), 32'd0);
      chk({tag, "_busy"},    32'(bus_a.BUSY),    32'd0);
      chk({tag, "_rad_out"}, 32'(bus_a.RAD_OUT), 32'd0);
      chk({tag, "_rad_oe"},  32'(bus_a.RAD_OE),  32'd0);
      chk({tag, "_ra_l"},    32'(bus_a.RA_L),    32'd0);
      chk({tag, "_ra_u"},    32'(bus_a.RA_U),    32'd0);
      chk({tag, "_rmpx"},    32'(bus_a.RMPX),    32'd0);
      chk({tag, "_nroe"},    32'(bus_a.nROE),    32'd1);
   endtask

   // ACK scoreboard monitors
   always @(negedge clk) begin
      exp_t e;
      if (bus_a.ACK != '0) begin
         if (exp_a.size() == 0) begin
            chk("a_ack_unexpected", 32'(bus_a.ACK), 32'd0);
         end else begin
            e = exp_a.pop_front();
            chk("a_ack_vec", 32'(bus_a.ACK),     32'd1 << e.ch);
            chk("a_rd_data", 32'(bus_a.RD_DATA), 32'(e.data));
            chk("a_gnt_idx", 32'(bus_a.GNT_IDX), 32'(e.ch));
            chk("a_ack_cyc", 32'(cyc),           32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus_b.ACK != '0) begin
         if (exp_b.size() == 0) begin
            chk("b_ack_unexpected", 32'(bus_b.ACK), 32'd0);
         end else begin
            e = exp_b.pop_front();
            chk("b_ack_vec", 32'(bus_b.ACK),     32'd1 << e.ch);
            chk("b_rd_data", 32'(bus_b.RD_DATA), 32'(e.data));
            chk("b_gnt_idx", 32'(bus_b.GNT_IDX), 32'(e.ch));
            chk("b_ack_cyc", 32'(cyc),           32'(e.cyc));
         end
      end
   end

   // Address phase monitor: RMPX rise carries the low half, RMPX fall the high half
   logic prev_rmpx_a = 1'b0;
   always @(negedge clk) begin
      ph_t p;
      if (bus_a.RMPX && !prev_rmpx_a) begin
         if (ph_a.size() == 0) begin
            chk("rmpx_rise_unexpected", 32'd1, 32'd0);
         end else begin
            p = ph_a[0];
            chk("lo_rad_out", 32'(bus_a.RAD_OUT), 32'(p.lo_rad));
            chk("lo_ra_l",    32'(bus_a.RA_L),    32'(p.lo_ral));
            chk("lo_rad_oe",  32'(bus_a.RAD_OE),  32'd1);
         end
      end else if (!bus_a.RMPX && prev_rmpx_a && !rst) begin
         if (ph_a.size() == 0) begin
            chk("rmpx_fall_unexpected", 32'd1, 32'd0);
         end else begin
            p = ph_a.pop_front();
            chk("hi_rad_out", 32'(bus_a.RAD_OUT), 32'(p.hi_rad));
            chk("hi_ra_l",    32'(bus_a.RA_L),    32'(p.hi_ral));
            chk("hi_ra_u",    32'(bus_a.RA_U),    32'(p.hi_rau));
            chk("hi_rad_oe",  32'(bus_a.RAD_OE),  32'd1);
         end
      end
      prev_rmpx_a = bus_a.RMPX;
   end

   // Bus contention and nROE pulse length
   int len_a = 0;
   int len_b = 0;
   always @(negedge clk) begin
      if (rst) begin
         len_a = 0;
         len_b = 0;
      end else begin
         if (bus_a.BUSY) chk("a_oe_while_nroe", 32'(bus_a.RAD_OE & ~bus_a.nROE), 32'd0);
         if (bus_b.BUSY) chk("b_oe_while_nroe", 32'(bus_b.RAD_OE & ~bus_b.nROE), 32'd0);
         if (!bus_a.nROE) len_a++;
         else if (len_a != 0) begin
            chk("a_nroe_len", 32'(len_a), 32'd2);
            len_a = 0;
         end
         if (!bus_b.nROE) len_b++;
         else if (len_b != 0) begin
            chk("b_nroe_len", 32'(len_b), 32'd5);
            len_b = 0;
         end
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_a.REQ = '0; bus_a.REQ_ADDR = '0; bus_a.RAD_IN = '0;
      bus_b.REQ = '0; bus_b.REQ_ADDR = '0; bus_b.RAD_IN = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_a("por");
      chk("por_b_nroe", 32'(bus_b.nROE), 32'd1);
      chk("por_b_busy", 32'(bus_b.BUSY), 32'd0);

      // Single access, channel 2, address 0xA5C3F1
      bus_a.RAD_IN = 8'h5A;
      set_addr_a(2, 24'hA5C3F1);
      exp_a.push_back('{2, 8'h5A, cyc + 7});
      ph_a.push_back('{8'hF1, 2'b11, 8'h70, 2'b01, 4'hA});
      bus_a.REQ = 6'b000100;
      wait_acks(1'b0, 1, "single");
      bus_a.REQ = '0;
      bus_a.RAD_IN = 8'h00;
      repeat (2) @(negedge clk);
      chk("rd_data_hold", 32'(bus_a.RD_DATA), 32'h5A);
      chk("gnt_idx_hold", 32'(bus_a.GNT_IDX), 32'd2);

      // Reset asserted while nROE is low
      bus_a.RAD_IN = 8'hE7;
      set_addr_a(3, 24'h13579B);
      ph_a.push_back(ph_of(24'h13579B));
      bus_a.REQ = 6'b001000;
      for (int t = 0; t < 20 && bus_a.nROE; t++) @(negedge clk);
      chk("reset_reached_read", 32'(bus_a.nROE), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk_reset_a("midrst");
      bus_a.REQ = '0;
      @(negedge clk);
      #3 rst = 1'b0;
      repeat (12) @(negedge clk);

      // Arbitration with requests held
      bus_a.RAD_IN = 8'h96;
      set_addr_a(0, 24'h000100);
      set_addr_a(1, 24'h0ABC12);
      set_addr_a(2, 24'h3FF3FF);
`ifdef VROM_SEQ_RR_EN
      push_a(0, 8'h96, cyc + 7,  24'h000100);
      push_a(1, 8'h96, cyc + 15, 24'h0ABC12);
      push_a(2, 8'h96, cyc + 23, 24'h3FF3FF);
      push_a(0, 8'h96, cyc + 31, 24'h000100);
      bus_a.REQ = 6'b000111;
      wait_acks(1'b0, 4, "rr");
`else
      push_a(1, 8'h96, cyc + 7,  24'h0ABC12);
      push_a(1, 8'h96, cyc + 15, 24'h0ABC12);
      push_a(1, 8'h96, cyc + 23, 24'h0ABC12);
      bus_a.REQ = 6'b000110;
      wait_acks(1'b0, 3, "fixed");
`endif
      bus_a.REQ = '0;
      repeat (3) @(negedge clk);

      // REQ_ADDR and REQ change during AHI
      bus_a.RAD_IN = 8'hC7;
      set_addr_a(4, 24'h0F00FF);
      push_a(4, 8'hC7, cyc + 7, 24'h0F00FF);
      bus_a.REQ = 6'b010000;
      repeat (3) @(negedge clk);
      chk("midchg_in_ahi", 32'(bus_a.RMPX & bus_a.RAD_OE), 32'd1);
      set_addr_a(4, 24'hFFFFFF);
      bus_a.REQ = '0;
      wait_acks(1'b0, 1, "midchg");
      repeat (3) @(negedge clk);

      // READ_CYC=5 instance
      bus_b.RAD_IN = 8'h81;
      bus_b.REQ_ADDR[23:0] = 24'h00ABCD;
      exp_b.push_back('{0, 8'h81, cyc + 10});
      bus_b.REQ = 6'b000001;
      wait_acks(1'b1, 1, "read5");
      bus_b.REQ = '0;
      repeat (3) @(negedge clk);

      chk("a_exp_drained",  32'(exp_a.size()), 32'd0);
      chk("a_ph_drained",   32'(ph_a.size()),  32'd0);
      chk("b_exp_drained",  32'(exp_b.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
